// File: rtl/cache_control_assoc.sv
// Control FSM for a WAYS-way set-associative write-back, write-allocate cache with per-set tree PLRU.
// Latency: hit completes in 2 cycles (IDLE, LOOKUP); a miss adds optional WRITEBACK, then FILL and REFETCH.
// Backpressure: CPU request is held until upstream_resp; memory phases stall until downstream_resp.
module cache_control_assoc #(
    parameter int WAYS      = 4,
    parameter int SET_IDX_W = 3,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upstream_read,
    input  logic                     upstream_write,
    output logic                     upstream_resp,
    input  logic [SET_IDX_W-1:0]     set_idx,
    input  logic [WAYS-1:0]          way_hit,
    input  logic [WAYS-1:0]          way_valid,
    input  logic [WAYS-1:0]          way_dirty,
    output logic                     cache_read,
    output logic [WAYS-1:0]          way_load,
    output logic                     new_dirty,
    output logic                     fill_sel,
    output logic [$clog2(WAYS)-1:0]  victim_way,
    output logic                     downstream_address_sel,
    output logic                     downstream_read,
    output logic                     downstream_write,
    input  logic                     downstream_resp,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 1 << SET_IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_FILL,
        ST_REFETCH
    } state_t;

    state_t state, state_nxt;

    // PLRU tree bits per set, heap-indexed: bit n is node n (root = 1).
    // Bit 0 has no tree node and always stays 0.
    logic [WAYS-1:0] plru_q [SETS];

    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             inv_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAYS-1:0]  plru_set;
    logic [WAY_W-1:0] victim_sel;
    logic             victim_dirty;
    logic             hit_evt;
    logic             miss_evt;

    // Walk from the root: a 0 bit goes left, a 1 bit goes right. The node
    // index doubles each level; after the last level the index is WAYS+way,
    // so truncating to WAY_W bits leaves the way number.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] bits);
        logic [WAY_W-1:0] n;
        n = WAY_W'(1);
        for (int l = 0; l < WAY_W; l++) begin
            n = (n << 1) | WAY_W'(bits[n]);
        end
        return n;
    endfunction

    // Climb from the leaf of the accessed way to the root, pointing every
    // node on the path at the sibling subtree (left child -> 1, right -> 0).
    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-1:0] b;
        logic [WAY_W:0]  n;
        b = bits;
        n = {1'b1, way};
        for (int l = 0; l < WAY_W; l++) begin
            b[n[WAY_W:1]] = ~n[0];
            n = {1'b0, n[WAY_W:1]};
        end
        return b;
    endfunction

    // Lowest-index hitting way and lowest-index invalid way.
    always_comb begin
        hit_any = |way_hit;
        inv_any = ~&way_valid;
        hit_way = '0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_way = WAY_W'(i);
            end
            if (!way_valid[i]) begin
                inv_way = WAY_W'(i);
            end
        end
    end

    // Victim choice: a free way beats the PLRU candidate.
    always_comb begin
        plru_set     = plru_q[set_idx];
        victim_sel   = inv_any ? inv_way : plru_victim(plru_set);
        victim_dirty = way_valid[victim_sel] & way_dirty[victim_sel];
    end

    assign hit_evt  = (state == ST_LOOKUP) &&  hit_any;
    assign miss_evt = (state == ST_LOOKUP) && !hit_any;

    // Next-state and all handshake/array-control outputs.
    always_comb begin
        state_nxt              = state;
        upstream_resp          = 1'b0;
        cache_read             = 1'b0;
        way_load               = '0;
        new_dirty              = 1'b0;
        fill_sel               = 1'b0;
        downstream_address_sel = 1'b0;
        downstream_read        = 1'b0;
        downstream_write       = 1'b0;
        case (state)
            ST_IDLE: begin
                cache_read = upstream_read | upstream_write;
                if (upstream_read || upstream_write) begin
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit_any) begin
                    upstream_resp = 1'b1;
                    // A write takes priority over a simultaneous read.
                    if (upstream_write) begin
                        way_load[hit_way] = 1'b1;
                        new_dirty         = 1'b1;
                        fill_sel          = 1'b0;
                    end
                    state_nxt = ST_IDLE;
                end else if (victim_dirty) begin
                    state_nxt = ST_WRITEBACK;
                end else begin
                    state_nxt = ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                if (downstream_resp) begin
                    state_nxt = ST_FILL;
                end else begin
                    downstream_write       = 1'b1;
                    downstream_address_sel = 1'b1;
                end
            end
            ST_FILL: begin
                if (downstream_resp) begin
                    way_load[victim_way] = 1'b1;
                    fill_sel             = 1'b1;
                    new_dirty            = 1'b0;
                    state_nxt            = ST_REFETCH;
                end else begin
                    downstream_read = 1'b1;
                end
            end
            ST_REFETCH: begin
                // Re-read the freshly filled line; the next LOOKUP hits.
                cache_read = 1'b1;
                state_nxt  = ST_LOOKUP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Victim latch: captured once per miss, held through writeback and fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            victim_way <= '0;
        end else if (miss_evt) begin
            victim_way <= victim_sel;
        end
    end

    // Hit/miss counters, wrapping naturally at 2**CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_evt) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

    // PLRU update: only hits touch the tree, since every fill ends in a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (hit_evt) begin
            plru_q[set_idx] <= plru_touch(plru_set, hit_way);
        end
    end

endmodule
